// File: rtl/zbb_bitcount_ctrl.sv
// zbb_bitcount_ctrl: sequencer for the Zbb bit-count ops (clz, ctz, cpop).
//   CLZ and CTZ share one leading-zero encoder. CTZ feeds it the bit-reversed operand.
//   CPOP accumulates CHUNK_W bits per cycle and stops once the remaining bits are all zero.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous flush, drops any op in flight
//   in_valid/ready  request handshake; in_op (00 clz, 01 ctz, 10 cpop, 11 reserved)
//   in_operand      rs1 value
//   out_valid/ready result handshake; out_result is the zero-extended count
//   busy            controller is not idle
module zbb_bitcount_ctrl #(
  parameter int unsigned CHUNK_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy
);

  localparam logic [1:0] OpClz  = 2'b00;
  localparam logic [1:0] OpCtz  = 2'b01;
  localparam logic [1:0] OpCpop = 2'b10;

  typedef enum logic [1:0] {StIdle, StCalc, StAcc, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d;   // operand; doubles as the remaining bits during CPOP
  logic [5:0]  acc_q, acc_d;
  logic [31:0] result_q, result_d;

  logic [31:0] operand_rev;
  logic [5:0]  clz_count;
  logic [5:0]  chunk_pop;

  // Leading-zero encoder shared by CLZ and CTZ; returns 32 for a zero operand.
  function automatic logic [5:0] clz_encoder(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd32;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(31 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  always_comb begin
    operand_rev = '0;
    for (int i = 0; i < 32; i++) begin
      operand_rev[i] = in_operand[31-i];
    end
  end

  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < int'(CHUNK_W); i++) begin
      chunk_pop = chunk_pop + 6'(opnd_q[i]);
    end
  end

  assign clz_count = clz_encoder(opnd_q);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (flush) begin
      // Flush wins over every handshake; out_result keeps its last value.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_d   = in_op;
            opnd_d = (in_op == OpCtz) ? operand_rev : in_operand;
            if (in_op == OpCpop) begin
              acc_d   = '0;
              state_d = StAcc;
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          result_d = (op_q == OpClz || op_q == OpCtz) ? {26'b0, clz_count} : '0;
          state_d  = StDone;
        end
        StAcc: begin
          acc_d  = acc_q + chunk_pop;
          opnd_d = opnd_q >> CHUNK_W;
          // Early exit once no set bits remain above this chunk.
          if (opnd_d == '0) begin
            result_d = {26'b0, acc_d};
            state_d  = StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign out_result = result_q;

endmodule

// File: tb/tb_zbb_bitcount_ctrl.sv
module tb_zbb_bitcount_ctrl;

  localparam int unsigned CW = 8;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  zbb_bitcount_ctrl #(.CHUNK_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_operand(in_operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts from the plain definitions.
  function automatic int ref_result(input logic [1:0] op, input logic [31:0] v);
    int n;
    n = 0;
    case (op)
      2'b00: begin
        while (n < 32 && v[31-n] == 1'b0) n++;
      end
      2'b01: begin
        while (n < 32 && v[n] == 1'b0) n++;
      end
      2'b10: begin
        for (int i = 0; i < 32; i++) n += int'(v[i]);
      end
      default: n = 0;
    endcase
    return n;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] v);
    int k;
    if (op != 2'b10) return 1;
    k = 1;
    for (int idx = 0; idx < 32 / int'(CW); idx++) begin
      if ((v >> (idx * int'(CW))) != 0) k = idx + 1;
    end
    return k;
  endfunction

  // Present a request at a falling edge; returns after the accept edge (+1).
  task automatic start_op(input logic [1:0] op, input logic [31:0] v);
    @(negedge clk);
    in_valid   = 1'b1;
    in_op      = op;
    in_operand = v;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_op      = 2'($urandom);
    in_operand = $urandom;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL accept op=%0d: busy=%0b required 1", op, busy);
    end
  endtask

  task automatic wait_result(input logic [1:0] op, input logic [31:0] v);
    int cnt;
    int exp_k;
    int exp_r;
    cnt   = 0;
    exp_k = ref_latency(op, v);
    exp_r = ref_result(op, v);
    while (out_valid !== 1'b1 && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checks++;
    if (cnt !== exp_k) begin
      errors++;
      $display("FAIL latency op=%0d v=%h: edges=%0d required %0d", op, v, cnt, exp_k);
    end
    checks++;
    if (out_result !== 32'(exp_r)) begin
      errors++;
      $display("FAIL result op=%0d v=%h: got %0d required %0d", op, v, out_result, exp_r);
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handshake: out_valid=%0b in_ready=%0b busy=%0b required 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] v);
    start_op(op, v);
    wait_result(op, v);
    handshake();
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: out_valid=%0b out_result=%h busy=%0b in_ready=%0b required 0 0 0 1",
               name, out_valid, out_result, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("after_reset");
  endtask

  task automatic test_directed();
    run_op(2'b00, 32'h0000_4020);
    run_op(2'b01, 32'h0000_4020);
    run_op(2'b01, 32'h0000_0000);
    run_op(2'b00, 32'h0000_0000);
    run_op(2'b00, 32'hFFFF_FFFF);
    run_op(2'b01, 32'hFFFF_FFFF);
    run_op(2'b11, 32'h1234_5678);
    run_op(2'b10, 32'h0F31_C7A3);
    run_op(2'b10, 32'h0000_00FF);
    run_op(2'b10, 32'h0000_0000);
    run_op(2'b10, 32'hFFFF_FFFF);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] v;
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      v  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = v << $urandom_range(0, 31);
      start_op(op, v);
      wait_result(op, v);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    start_op(2'b00, 32'h0000_4020);
    wait_result(2'b00, 32'h0000_4020);
    held = out_result;
    @(negedge clk);
    in_valid   = 1'b1;
    in_op      = 2'b10;
    in_operand = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure cycle %0d: out_valid=%0b out_result=%h in_ready=%0b required 1 %h 0",
                 i, out_valid, out_result, in_ready, held);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure release: out_valid=%0b in_ready=%0b required 0 1",
               out_valid, in_ready);
    end
    run_op(2'b10, 32'h0000_0F0F);
  endtask

  task automatic test_reset_mid();
    run_op(2'b00, 32'h0000_4020);
    start_op(2'b10, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    // Now in the second ACC cycle.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("reset_mid_acc");
    @(posedge clk);
    #1;
    check_reset_values("reset_mid_hold");
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b10, 32'h0000_0003);
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    run_op(2'b00, 32'h0000_4020);
    prev = out_result;
    // Flush while in CALC.
    start_op(2'b01, 32'h0000_0100);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_result !== prev) begin
      errors++;
      $display("FAIL flush_calc: out_valid=%0b busy=%0b in_ready=%0b out_result=%h required 0 0 1 %h",
               out_valid, busy, in_ready, out_result, prev);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc_later: out_valid=%0b required 0", out_valid);
    end
    // Flush while in DONE with out_ready also high.
    start_op(2'b10, 32'h00F0_0000);
    wait_result(2'b10, 32'h00F0_0000);
    prev = out_result;
    @(negedge clk);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== prev) begin
      errors++;
      $display("FAIL flush_done: out_valid=%0b busy=%0b out_result=%h required 0 0 %h",
               out_valid, busy, out_result, prev);
    end
    // Request together with flush is not accepted.
    @(negedge clk);
    flush      = 1'b1;
    in_valid   = 1'b1;
    in_op      = 2'b00;
    in_operand = 32'h0000_0001;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_with_request: busy=%0b in_ready=%0b required 0 1", busy, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_with_request_later: out_valid=%0b required 0", out_valid);
    end
    run_op(2'b01, 32'h8000_0000);
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_op      = 2'b00;
    in_operand = '0;
    out_ready  = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
